// File: rtl/cisc_bus_pkg.sv
// Shared encodings for the cisc external-bus memory responder.
package cisc_bus_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_ERR = 2'd2
    } op_e;

    // rd and wr together is a protocol error rather than either access
    function automatic op_e decode_op(input logic rd, input logic wr);
        op_e op;
        if (rd && wr) begin
            op = OP_ERR;
        end else if (wr) begin
            op = OP_WR;
        end else begin
            op = OP_RD;
        end
        return op;
    endfunction

endpackage

// File: rtl/cisc_mem_array.sv
// Program/data storage: one synchronous write port, one asynchronous read port.
module cisc_mem_array
    import cisc_bus_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // contents deliberately survive reset so a preloaded program is kept
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/cisc_ext_mem.sv
// External-bus memory responder: latches one request, waits WAIT_STATES cycles,
// performs the access and pulses rdy (and err for rd&wr) for one cycle.
module cisc_ext_mem
    import cisc_bus_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] eab,
    input  logic [DW-1:0] dout,
    input  logic          rd,
    input  logic          wr,
    output logic [DW-1:0] edb,
    output logic          rdy,
    output logic          err,
    output logic          busy,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    localparam bit             ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT =
        ZERO_WAIT ? {CNT_W{1'b0}} : CNT_W'(WAIT_STATES - 1);

    state_e           state_r;
    op_e              op_r;
    logic [AW-1:0]    addr_r;
    logic [DW-1:0]    data_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DW-1:0]    edb_r;
    logic             rdy_r;
    logic             err_r;
    logic             busy_r;

    logic             req_s;
    logic             done_entry_s;
    op_e              done_op_s;
    logic [AW-1:0]    done_addr_s;
    logic [DW-1:0]    done_data_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_waddr_s;
    logic [DW-1:0]    mem_wdata_s;
    logic [DW-1:0]    mem_rdata_s;

    assign req_s = rd | wr;

    // Identify the edge that enters DONE and which access it performs; with no
    // wait states that edge is the sampling edge itself, so live bus values apply.
    always_comb begin
        done_entry_s = 1'b0;
        done_op_s    = op_r;
        done_addr_s  = addr_r;
        done_data_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (ZERO_WAIT && req_s) begin
                    done_entry_s = 1'b1;
                    done_op_s    = decode_op(rd, wr);
                    done_addr_s  = eab;
                    done_data_s  = dout;
                end else begin
                    done_entry_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    done_entry_s = 1'b1;
                end else begin
                    done_entry_s = 1'b0;
                end
            end
            default: begin
                done_entry_s = 1'b0;
            end
        endcase
    end

    // Write-port mux: loader owns the port during reset, which also drops any pending write.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = ld_addr;
        mem_wdata_s = ld_data;
        if (!reset) begin
            mem_we_s = ld_en;
        end else if (done_entry_s && (done_op_s == OP_WR)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = done_addr_s;
            mem_wdata_s = done_data_s;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    cisc_mem_array #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .raddr (done_addr_s),
        .rdata (mem_rdata_s)
    );

    // Access FSM with request latches, wait counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            op_r    <= OP_RD;
            addr_r  <= {AW{1'b0}};
            data_r  <= {DW{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            edb_r   <= {DW{1'b0}};
            rdy_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            rdy_r <= 1'b0;
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        op_r   <= decode_op(rd, wr);
                        addr_r <= eab;
                        data_r <= dout;
                        busy_r <= 1'b1;
                        if (ZERO_WAIT) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            if (done_entry_s) begin
                rdy_r <= 1'b1;
                err_r <= (done_op_s == OP_ERR);
                if (done_op_s == OP_RD) begin
                    edb_r <= mem_rdata_s;
                end
            end
        end
    end

    assign edb  = edb_r;
    assign rdy  = rdy_r;
    assign err  = err_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_cisc_ext_mem.sv
// Bench for cisc_ext_mem: a 2-wait-state and a zero-wait-state instance sharing
// clock, reset and loader, checked with vector tables, directed sequences and a memory model.
module tb_cisc_ext_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    logic [7:0] eab2, dout2, edb2;
    logic       rd2, wr2, rdy2, err2, busy2;
    logic [7:0] eab0, dout0, edb0;
    logic       rd0, wr0, rdy0, err0, busy0;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_mem2 [0:255];
    logic [7:0] m_mem0 [0:255];
    logic [7:0] m_edb2;
    logic [7:0] m_edb0;

    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;
    localparam logic [1:0] BOTH = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_edb;
        logic       exp_err;
    } vec_t;

    always #5 clk = ~clk;

    cisc_ext_mem #(.AW(8), .DW(8), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .eab(eab2), .dout(dout2), .rd(rd2), .wr(wr2),
        .edb(edb2), .rdy(rdy2), .err(err2), .busy(busy2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    cisc_ext_mem #(.AW(8), .DW(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .eab(eab0), .dout(dout0), .rd(rd0), .wr(wr0),
        .edb(edb0), .rdy(rdy0), .err(err0), .busy(busy0),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (sel) begin
            rd0 = r; wr0 = w; eab0 = a; dout0 = d;
        end else begin
            rd2 = r; wr2 = w; eab2 = a; dout2 = d;
        end
    endtask

    function automatic logic get_rdy(input bit sel);
        return sel ? rdy0 : rdy2;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? err0 : err2;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy0 : busy2;
    endfunction
    function automatic logic [7:0] get_edb(input bit sel);
        return sel ? edb0 : edb2;
    endfunction

    // Reference behaviour of one completed access.
    task automatic model(input bit sel, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] d, output logic [7:0] exp_edb, output logic exp_err);
        exp_err = (op == BOTH);
        if (op == WR) begin
            if (sel) m_mem0[a] = d; else m_mem2[a] = d;
        end else if (op == RD) begin
            if (sel) m_edb0 = m_mem0[a]; else m_edb2 = m_mem2[a];
        end
        exp_edb = sel ? m_edb0 : m_edb2;
    endtask

    // Entered and left #1 after a rising edge.
    task automatic access(input bit sel, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] d, input string name,
                          output logic [7:0] act_edb, output logic act_err);
        int         edges;
        bit         got;
        logic [7:0] prev_edb;
        logic [7:0] exp_edb;
        logic       exp_err;
        prev_edb = sel ? m_edb0 : m_edb2;
        model(sel, op, a, d, exp_edb, exp_err);
        drive(sel, op[0], op[1], a, d);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (get_rdy(sel)) begin
                got = 1'b1;
            end else begin
                chk({name, " busy in wait"}, 32'(get_busy(sel)), 32'd1);
                chk({name, " edb held"}, 32'(get_edb(sel)), 32'(prev_edb));
                drive(sel, op[0], op[1], 8'($urandom), 8'($urandom));
            end
        end
        chk({name, " rdy seen"}, 32'(got), 32'd1);
        chk({name, " latency edges"}, 32'(edges), sel ? 32'd1 : 32'd3);
        act_edb = get_edb(sel);
        act_err = get_err(sel);
        chk({name, " edb"}, 32'(act_edb), 32'(exp_edb));
        chk({name, " err"}, 32'(act_err), 32'(exp_err));
        chk({name, " busy at rdy"}, 32'(get_busy(sel)), 32'd1);
        drive(sel, 1'b0, 1'b0, a, d);
        @(posedge clk); #1;
        chk({name, " rdy one cycle"}, 32'(get_rdy(sel)), 32'd0);
        chk({name, " err one cycle"}, 32'(get_err(sel)), 32'd0);
        chk({name, " idle busy"}, 32'(get_busy(sel)), 32'd0);
    endtask

    initial begin
        vec_t       tbl [6];
        logic [7:0] e;
        logic       r;
        int         t1;
        int         t2;
        int         edges;

        tbl[0] = '{RD,   8'h01, 8'h00, 8'hA5, 1'b0};
        tbl[1] = '{WR,   8'h10, 8'h5A, 8'hA5, 1'b0};
        tbl[2] = '{RD,   8'h10, 8'h00, 8'h5A, 1'b0};
        tbl[3] = '{BOTH, 8'h01, 8'h77, 8'h5A, 1'b1};
        tbl[4] = '{RD,   8'h01, 8'h00, 8'hA5, 1'b0};
        tbl[5] = '{RD,   8'h00, 8'h00, 8'h3C, 1'b0};

        reset = 1'b0;
        ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        m_edb2 = 8'h00;
        m_edb0 = 8'h00;

        // preload every location while both responders are held in reset
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            ld_data = (i == 0) ? 8'h3C : (i == 1) ? 8'hA5 : (i == 32) ? 8'h00 : 8'($urandom);
            m_mem2[i] = ld_data;
            m_mem0[i] = ld_data;
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
        chk("reset edb", 32'(edb2), 32'h0);
        chk("reset rdy", 32'(rdy2), 32'h0);
        chk("reset err", 32'(err2), 32'h0);
        chk("reset busy", 32'(busy2), 32'h0);
        chk("reset0 edb", 32'(edb0), 32'h0);
        chk("reset0 busy", 32'(busy0), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            access(1'b0, tbl[i].op, tbl[i].addr, tbl[i].data, $sformatf("vec%0d", i), e, r);
            chk($sformatf("vec%0d table edb", i), 32'(e), 32'(tbl[i].exp_edb));
            chk($sformatf("vec%0d table err", i), 32'(r), 32'(tbl[i].exp_err));
        end

        access(1'b1, RD, 8'h01, 8'h00, "ws0 read", e, r);
        chk("ws0 read table edb", 32'(e), 32'hA5);

        // mid-access reset: the write is aborted just before it would complete
        drive(1'b0, 1'b0, 1'b1, 8'h20, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk("abort rdy", 32'(rdy2), 32'h0);
        chk("abort busy", 32'(busy2), 32'h0);
        chk("abort edb", 32'(edb2), 32'h0);
        m_edb2 = 8'h00;
        m_edb0 = 8'h00;
        reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, RD, 8'h20, 8'h00, "after abort", e, r);
        chk("after abort table edb", 32'(e), 32'h00);

        // held read: a second access starts right after the first completes
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        t1 = 0; t2 = 0; edges = 0;
        while (t2 == 0 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (rdy2) begin
                chk("held edb", 32'(edb2), 32'h3C);
                if (t1 == 0) t1 = edges; else t2 = edges;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("held first rdy", 32'(t1), 32'd3);
        chk("held spacing", 32'(t2 - t1), 32'd4);
        m_edb2 = 8'h3C;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("held idle busy", 32'(busy2), 32'h0);

        // loader strobes outside reset must not touch memory
        ld_en = 1'b1; ld_addr = 8'h01; ld_data = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        ld_en = 1'b0;
        access(1'b0, RD, 8'h01, 8'h00, "ld ignored", e, r);
        chk("ld ignored table edb", 32'(e), 32'hA5);
        access(1'b1, RD, 8'h01, 8'h00, "ws0 ld ignored", e, r);
        chk("ws0 ld ignored table edb", 32'(e), 32'hA5);

        for (int i = 0; i < 60; i++) begin
            bit         sel;
            logic [1:0] op;
            logic [7:0] a;
            sel = ($urandom_range(0, 3) == 0);
            op  = ($urandom_range(0, 9) == 0) ? BOTH : ($urandom_range(0, 1) == 0 ? RD : WR);
            a   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            access(sel, op, a, 8'($urandom), $sformatf("rand%0d", i), e, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cisc_ext_mem.md
Name: cisc_ext_mem

Overview:
- External-bus memory responder for the cisc CPU: the target end of the CPU's external address/data bus (eab/dout out of the CPU, edb back in).
- Holds program and data (2^AW x DW words) and serves one read or write per request.
- Inserts a fixed, parameterised number of wait states and signals completion with a one-cycle rdy pulse.
- Includes a loader port for preloading the program while the CPU is held in reset.

Parameters:
- AW, 8, address width (matches eab).
- DW, 8, data width (matches edb/dout).
- WAIT_STATES, 2, wait cycles inserted before rdy; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- eab  input  AW  CPU external address.
- dout  input  DW  CPU write data.
- rd  input  1  CPU read request (level).
- wr  input  1  CPU write request (level).
- edb  output  DW  read data returned to CPU.
- rdy  output  1  access-complete pulse, one cycle.
- err  output  1  protocol-error pulse, one cycle, coincident with rdy.
- busy  output  1  high while an access is in progress (WAIT or DONE).
- ld_en  input  1  loader write strobe.
- ld_addr  input  AW  loader address.
- ld_data  input  DW  loader data.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, edb=0, rdy=0, err=0, busy=0, wait counter=0. Memory contents are preserved. An in-flight access is aborted and its pending write is discarded.
- Loader: while reset==0, ld_en=1 writes mem[ld_addr]=ld_data at the clk edge. ld_en is ignored while reset==1.
- State IDLE:
  - Request sampled at a clk edge when rd|wr=1.
  - On sampling, latch eab, dout and the operation (RD, WR or ERR when rd&wr).
  - Next state is WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else DONE.
- State WAIT: decrement cnt each cycle. Leave for DONE on the edge where cnt==0.
  - rd/wr/eab/dout changes during WAIT are ignored; latched values are used.
- Entering DONE (same edge):
  - RD: edb <= mem[latched addr].
  - WR: mem[latched addr] <= latched data; edb unchanged.
  - ERR: no memory access, edb unchanged, err=1.
- State DONE: rdy=1 (err=1 if ERR) for exactly one cycle. Next state IDLE unconditionally.
- Latency: rdy is high in the cycle that starts WAIT_STATES+1 edges after the request-sampling edge.
- Back-to-back requests: the CPU must drop rd/wr in the rdy cycle. If the request is still high in IDLE, it is sampled as a new access (no merging).
- edb holds the last read value until the next completed read or reset.
- busy=1 in WAIT and DONE, 0 in IDLE.
- Address wrap: none needed; the full 2^AW space is implemented. Out-of-range cannot occur.
- Read-after-write to the same address in consecutive accesses returns the new data.

Decomposition:
- Package cisc_bus_pkg holds:
  - state encoding IDLE/WAIT/DONE (2-bit);
  - op encoding RD/WR/ERR;
  - AW/DW default constants;
  - wait-counter width (4).
- Sub-module cisc_mem_array: 2^AW x DW array with one synchronous write port (muxed between the loader and the access engine), one asynchronous read port, and no reset.
- The FSM, latches and counter live in cisc_ext_mem.

Test Plan:
- Preload during reset: with reset=0, load mem[0x00]=0x3C and mem[0x01]=0xA5; release reset. Read 0x01 -> rdy 3 cycles after sampling (WAIT_STATES=2), edb=0xA5, err=0.
- Write then read: write 0x5A to 0x10, wait for rdy, drop wr; read 0x10 -> edb=0x5A. The preceding edb value persists until that read completes.
- Simultaneous rd&wr to 0x01 (mem=0xA5) -> rdy and err pulse together, mem[0x01] still 0xA5, edb unchanged.
- Mid-access reset: start a write of 0xFF to 0x20 (old 0x00). Assert reset during WAIT -> rdy/busy=0 next edge; later read of 0x20 returns 0x00.
- Held request: keep rd=1 through rdy with addr 0x00 -> a second access is sampled the cycle after rdy; two rdy pulses 4 cycles apart, both edb=0x3C.
- WAIT_STATES=0 build: read 0x01 -> rdy on the cycle after sampling, edb=0xA5. Loader with reset=1 and ld_en=1 to 0x01 leaves the data unchanged.
